// File: rtl/rv32i_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_ctrl_seq
// Description : Multi-cycle RV32I control sequencer. Accepts one instruction
//               at a time over a valid/ready handshake and steps it through
//               IDLE/EXEC/ADDR/LOAD/STORE, emitting one Datapath control word
//               per cycle plus data-memory strobes and branch resolution.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_ctrl_seq #(
  parameter int         depth  = 32,
  parameter int         width  = 32,
  parameter int         SCR    = 31,
  parameter logic [3:0] FS_ADD = 4'b0010,
  parameter logic [3:0] FS_SUB = 4'b0101,
  parameter logic [3:0] FS_SLL = 4'b1101,
  parameter logic [3:0] FS_SRL = 4'b1110,
  parameter logic [3:0] FS_AND = 4'b1000,
  parameter logic [3:0] FS_OR  = 4'b1001,
  parameter logic [3:0] FS_XOR = 4'b1010
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [width-1:0]         instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic                     V,
  input  logic                     C,
  input  logic                     N,
  input  logic                     Z,
  output logic [$clog2(depth)-1:0] waddr,
  output logic [$clog2(depth)-1:0] raddr0,
  output logic [$clog2(depth)-1:0] raddr1,
  output logic                     MB,
  output logic [3:0]               FS,
  output logic                     MD,
  output logic [2:0]               wstrobe,
  output logic                     we,
  output logic [4:0]               shamnt,
  output logic [width-1:0]         ConsIn,
  output logic                     mem_we,
  output logic [2:0]               mem_wstrobe,
  output logic                     done,
  output logic                     br_valid,
  output logic                     br_taken,
  output logic [width-1:0]         br_offset,
  output logic                     illegal
);

  localparam int AW = $clog2(depth);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  // Scratch register index in instruction-field width and in address width
  localparam logic [4:0]    SCR_R = 5'(SCR);
  localparam logic [AW-1:0] SCR_A = AW'(SCR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_ADDR  = 3'd2,
    S_LOAD  = 3'd3,
    S_STORE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_ILL  = 2'd0,
    CLS_EXEC = 2'd1,
    CLS_MEM  = 2'd2
  } cls_t;

  state_t      state_q;
  logic [31:0] ir_q;
  logic        illegal_q;

  // The carry flag has no consumer among the supported branches
  logic unused_c;
  assign unused_c = C;

  // --------------------------------------------------------------------------
  // Classification of the instruction offered on the fetch port
  // --------------------------------------------------------------------------
  logic [6:0] a_op;
  logic [2:0] a_f3;
  logic [6:0] a_f7;
  logic [4:0] a_rd;
  logic [4:0] a_rs1;
  logic [4:0] a_rs2;
  cls_t       acc_cls;

  assign a_op  = instr[6:0];
  assign a_rd  = instr[11:7];
  assign a_f3  = instr[14:12];
  assign a_rs1 = instr[19:15];
  assign a_rs2 = instr[24:20];
  assign a_f7  = instr[31:25];

  // Decide where an accepted instruction goes; anything unlisted is illegal
  always_comb begin
    acc_cls = CLS_ILL;
    case (a_op)
      OP_R: begin
        if (a_f7 == 7'b0000000 &&
            (a_f3 == 3'b000 || a_f3 == 3'b111 || a_f3 == 3'b110 || a_f3 == 3'b100))
          acc_cls = CLS_EXEC;
        else if (a_f7 == 7'b0100000 && a_f3 == 3'b000)
          acc_cls = CLS_EXEC;
      end
      OP_I: begin
        case (a_f3)
          3'b000, 3'b111, 3'b110, 3'b100: acc_cls = CLS_EXEC;
          3'b001, 3'b101: if (a_f7 == 7'b0000000) acc_cls = CLS_EXEC;
          default: acc_cls = CLS_ILL;
        endcase
      end
      OP_BR: begin
        case (a_f3)
          3'b000, 3'b001, 3'b100, 3'b101: acc_cls = CLS_EXEC;
          default: acc_cls = CLS_ILL;
        endcase
      end
      // The scratch register carries the computed address, so a load/store
      // must not name it or the address would be clobbered or misread.
      OP_LD: begin
        if (a_f3 <= 3'b010 && a_rs1 != SCR_R && a_rd != SCR_R)
          acc_cls = CLS_MEM;
      end
      OP_ST: begin
        if (a_f3 <= 3'b010 && a_rs1 != SCR_R && a_rs2 != SCR_R)
          acc_cls = CLS_MEM;
      end
      default: acc_cls = CLS_ILL;
    endcase
  end

  // Sequencer state, instruction latch and one-cycle illegal pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            ir_q <= instr[31:0];
            case (acc_cls)
              CLS_EXEC: state_q <= S_EXEC;
              CLS_MEM:  state_q <= S_ADDR;
              default:  illegal_q <= 1'b1;
            endcase
          end
        end
        S_EXEC:  state_q <= S_IDLE;
        S_ADDR:  state_q <= (ir_q[6:0] == OP_LD) ? S_LOAD : S_STORE;
        S_LOAD:  state_q <= S_IDLE;
        S_STORE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Fields of the latched instruction
  // --------------------------------------------------------------------------
  logic [6:0]       op_q;
  logic [2:0]       f3_q;
  logic [AW-1:0]    rd_a;
  logic [AW-1:0]    rs1_a;
  logic [AW-1:0]    rs2_a;
  logic             rd_nz;
  logic [width-1:0] imm_i_x;
  logic [width-1:0] imm_s_x;
  logic [width-1:0] br_off_x;
  logic [3:0]       alu_fs;
  logic [2:0]       size_st;

  assign op_q     = ir_q[6:0];
  assign f3_q     = ir_q[14:12];
  assign rd_a     = AW'(ir_q[11:7]);
  assign rs1_a    = AW'(ir_q[19:15]);
  assign rs2_a    = AW'(ir_q[24:20]);
  assign rd_nz    = (ir_q[11:7] != 5'd0);
  assign imm_i_x  = {{(width-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s_x  = {{(width-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign br_off_x = {{(width-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                     ir_q[11:8], 1'b0};

  // Datapath function for ALU-class instructions; bit 30 selects SUB only on R-type
  always_comb begin
    case (f3_q)
      3'b000:  alu_fs = (op_q == OP_R && ir_q[30]) ? FS_SUB : FS_ADD;
      3'b001:  alu_fs = FS_SLL;
      3'b101:  alu_fs = FS_SRL;
      3'b100:  alu_fs = FS_XOR;
      3'b110:  alu_fs = FS_OR;
      3'b111:  alu_fs = FS_AND;
      default: alu_fs = FS_ADD;
    endcase
  end

  // Access size strobe for loads/stores: byte, half, word
  always_comb begin
    case (f3_q[1:0])
      2'b00:   size_st = 3'b001;
      2'b01:   size_st = 3'b010;
      default: size_st = 3'b100;
    endcase
  end

  // Control word for the current cycle; everything held at 0 while in reset
  always_comb begin
    instr_ready = 1'b0;
    waddr       = '0;
    raddr0      = '0;
    raddr1      = '0;
    MB          = 1'b0;
    FS          = '0;
    MD          = 1'b0;
    wstrobe     = '0;
    we          = 1'b0;
    shamnt      = '0;
    ConsIn      = '0;
    mem_we      = 1'b0;
    mem_wstrobe = '0;
    done        = 1'b0;
    br_valid    = 1'b0;
    br_taken    = 1'b0;
    br_offset   = '0;
    illegal     = 1'b0;
    if (rst) begin
      illegal = illegal_q;
      case (state_q)
        S_IDLE: instr_ready = 1'b1;
        S_EXEC: begin
          done   = 1'b1;
          raddr0 = rs1_a;
          if (op_q == OP_BR) begin
            raddr1    = rs2_a;
            FS        = FS_SUB;
            br_valid  = 1'b1;
            br_offset = br_off_x;
            case (f3_q)
              3'b000:  br_taken = Z;
              3'b001:  br_taken = ~Z;
              3'b100:  br_taken = N ^ V;
              default: br_taken = ~(N ^ V);
            endcase
          end else begin
            waddr   = rd_a;
            we      = rd_nz;
            wstrobe = rd_nz ? 3'b100 : 3'b000;
            FS      = alu_fs;
            if (op_q == OP_R) begin
              raddr1 = rs2_a;
            end else if (f3_q == 3'b001 || f3_q == 3'b101) begin
              shamnt = ir_q[24:20];
            end else begin
              MB     = 1'b1;
              ConsIn = imm_i_x;
            end
          end
        end
        // Effective address goes into the scratch register, even when rd is x0
        S_ADDR: begin
          waddr   = SCR_A;
          raddr0  = rs1_a;
          MB      = 1'b1;
          FS      = FS_ADD;
          ConsIn  = (op_q == OP_LD) ? imm_i_x : imm_s_x;
          we      = 1'b1;
          wstrobe = 3'b100;
        end
        S_LOAD: begin
          done    = 1'b1;
          waddr   = rd_a;
          raddr0  = SCR_A;
          MD      = 1'b1;
          we      = rd_nz;
          wstrobe = rd_nz ? size_st : 3'b000;
        end
        S_STORE: begin
          done        = 1'b1;
          raddr0      = SCR_A;
          raddr1      = rs2_a;
          mem_we      = 1'b1;
          mem_wstrobe = size_st;
        end
        default: instr_ready = 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_ctrl_seq
// Description : Self-checking bench for rv32i_ctrl_seq. An ISA-level
//               mask/match decoder builds the expected per-cycle control
//               words, which are compared against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_ctrl_seq;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        V, C, N, Z;
  logic [4:0]  waddr, raddr0, raddr1;
  logic        MB;
  logic [3:0]  FS;
  logic        MD;
  logic [2:0]  wstrobe;
  logic        we;
  logic [4:0]  shamnt;
  logic [31:0] ConsIn;
  logic        mem_we;
  logic [2:0]  mem_wstrobe;
  logic        done;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        illegal;

  rv32i_ctrl_seq dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .V(V), .C(C), .N(N), .Z(Z),
    .waddr(waddr), .raddr0(raddr0), .raddr1(raddr1), .MB(MB), .FS(FS), .MD(MD),
    .wstrobe(wstrobe), .we(we), .shamnt(shamnt), .ConsIn(ConsIn),
    .mem_we(mem_we), .mem_wstrobe(mem_wstrobe), .done(done),
    .br_valid(br_valid), .br_taken(br_taken), .br_offset(br_offset),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] FS_ADD = 4'b0010;
  localparam logic [3:0] FS_SUB = 4'b0101;

  // ADD SUB AND OR XOR | ADDI ANDI ORI XORI | SLLI SRLI | BEQ BNE BLT BGE | LB LH LW | SB SH SW
  localparam logic [31:0] MASKS [21] = '{
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
    32'hFE00707F, 32'hFE00707F,
    32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
    32'h0000707F, 32'h0000707F, 32'h0000707F,
    32'h0000707F, 32'h0000707F, 32'h0000707F};
  localparam logic [31:0] MATCH [21] = '{
    32'h00000033, 32'h40000033, 32'h00007033, 32'h00006033, 32'h00004033,
    32'h00000013, 32'h00007013, 32'h00006013, 32'h00004013,
    32'h00001013, 32'h00005013,
    32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063,
    32'h00000003, 32'h00001003, 32'h00002003,
    32'h00000023, 32'h00001023, 32'h00002023};
  localparam logic [3:0] FS_TAB [21] = '{
    4'b0010, 4'b0101, 4'b1000, 4'b1001, 4'b1010,
    4'b0010, 4'b1000, 4'b1001, 4'b1010,
    4'b1101, 4'b1110,
    4'b0101, 4'b0101, 4'b0101, 4'b0101,
    4'b0010, 4'b0010, 4'b0010,
    4'b0010, 4'b0010, 4'b0010};

  typedef struct packed {
    logic        ready;
    logic        illegal;
    logic        done;
    logic [4:0]  waddr;
    logic [4:0]  raddr0;
    logic [4:0]  raddr1;
    logic        mb;
    logic [3:0]  fs;
    logic        md;
    logic [2:0]  wstrobe;
    logic        we;
    logic [4:0]  shamnt;
    logic [31:0] cons;
    logic        mem_we;
    logic [2:0]  mem_wstrobe;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_offset;
  } ctl_t;

  int   tests;
  int   fails;
  ctl_t obs [8];
  ctl_t exp_q [$];

  function automatic ctl_t cap();
    ctl_t c;
    c.ready = instr_ready;  c.illegal = illegal;  c.done = done;
    c.waddr = waddr;  c.raddr0 = raddr0;  c.raddr1 = raddr1;
    c.mb = MB;  c.fs = FS;  c.md = MD;  c.wstrobe = wstrobe;  c.we = we;
    c.shamnt = shamnt;  c.cons = ConsIn;  c.mem_we = mem_we;
    c.mem_wstrobe = mem_wstrobe;  c.br_valid = br_valid;
    c.br_taken = br_taken;  c.br_offset = br_offset;
    return c;
  endfunction

  function automatic ctl_t idle_c(input logic ill);
    ctl_t c;
    c = '0;
    c.ready = 1'b1;
    c.illegal = ill;
    return c;
  endfunction

  // ISA-level decode: table index of the mnemonic, or -1 when unsupported
  function automatic int decode(input logic [31:0] ins);
    int m = -1;
    for (int i = 0; i < 21; i++)
      if ((ins & MASKS[i]) == MATCH[i]) m = i;
    if (m >= 15 && m <= 17 && (ins[19:15] == 5'd31 || ins[11:7] == 5'd31)) m = -1;
    if (m >= 18 && (ins[19:15] == 5'd31 || ins[24:20] == 5'd31)) m = -1;
    return m;
  endfunction

  // Reference model: append the expected cycles following acceptance of ins
  task automatic push_seq(input logic [31:0] ins, input logic [3:0] vcnz, output int len);
    int         m, immi, imms, boff;
    logic [11:0] s12, b12;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] sz;
    logic       fv, fn, fz;
    ctl_t       c;
    m = decode(ins);
    fv = vcnz[3]; fn = vcnz[1]; fz = vcnz[0];
    rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
    immi = $signed(ins[31:20]);
    s12 = {ins[31:25], ins[11:7]};
    imms = $signed(s12);
    b12 = {ins[31], ins[7], ins[30:25], ins[11:8]};
    boff = $signed(b12);
    boff = boff * 2;
    c = '0;
    len = 1;
    if (m < 0) begin
      c = idle_c(1'b1);
    end else if (m <= 10) begin
      c.done = 1'b1; c.waddr = rd; c.raddr0 = rs1; c.fs = FS_TAB[m];
      if (m <= 4) c.raddr1 = rs2;
      else if (m <= 8) begin c.mb = 1'b1; c.cons = immi; end
      else c.shamnt = ins[24:20];
      c.we = (rd != 5'd0);
      c.wstrobe = c.we ? 3'b100 : 3'b000;
    end else if (m <= 14) begin
      c.done = 1'b1; c.raddr0 = rs1; c.raddr1 = rs2; c.fs = FS_SUB;
      c.br_valid = 1'b1; c.br_offset = boff;
      case (m)
        11:      c.br_taken = fz;
        12:      c.br_taken = !fz;
        13:      c.br_taken = (fn != fv);
        default: c.br_taken = (fn == fv);
      endcase
    end else begin
      sz = 3'(1 << ((m - 15) % 3));
      c.waddr = 5'd31; c.raddr0 = rs1; c.mb = 1'b1; c.fs = FS_ADD;
      c.cons = (m <= 17) ? immi : imms; c.we = 1'b1; c.wstrobe = 3'b100;
      exp_q.push_back(c);
      c = '0;
      len = 2;
      c.done = 1'b1; c.raddr0 = 5'd31;
      if (m <= 17) begin
        c.waddr = rd; c.md = 1'b1; c.we = (rd != 5'd0);
        c.wstrobe = c.we ? sz : 3'b000;
      end else begin
        c.raddr1 = rs2; c.mem_we = 1'b1; c.mem_wstrobe = sz;
      end
    end
    exp_q.push_back(c);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int m;
    w = $urandom;
    if ($urandom_range(0, 7) == 0) w[19:15] = 5'd31;
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd31;
    if ($urandom_range(0, 7) == 0) w[24:20] = 5'd31;
    if ($urandom_range(0, 15) == 0) w[11:7] = 5'd0;
    if ($urandom_range(0, 9) == 0) return w;
    m = $urandom_range(0, 20);
    w = (w & ~MASKS[m]) | MATCH[m];
    if ($urandom_range(0, 15) == 0) w[30] = ~w[30];
    return w;
  endfunction

  // Stimulus only: present i0 (and optionally i1 straight after), capture n cycles.
  // Entered and left one time unit after a rising edge.
  task automatic run(input logic [31:0] i0, input logic [31:0] i1, input bit v1,
                     input logic [3:0] vcnz, input int n);
    {V, C, N, Z} = vcnz;
    instr = i0;
    instr_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs[k] = cap();
      if (k == n - 1) instr_valid = 1'b0;
      @(posedge clk);
      #1;
      if (k == 0) begin
        if (v1) instr = i1;
        else begin instr = $urandom; instr_valid = 1'b0; end
      end
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    ctl_t e;
    @(posedge clk); #1;
    instr = 32'h00500093;
    instr_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = '0;
      tests++;
      if (cap() !== e) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: got %h expected %h", k, cap(), e);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    e = idle_c(1'b0);
    tests++;
    if (cap() !== e) begin
      fails++;
      $display("FAIL reset_release: got %h expected %h", cap(), e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] ins [14] = '{32'h00500093, 32'h402081B3, 32'h0040A103, 32'h00208023,
                              32'h00208463, 32'h00208463, 32'hFFFFFFFF, 32'h00209133,
                              32'h000FA103, 32'h01F0A023, 32'h0000AF83, 32'h00500013,
                              32'h0040A003, 32'hFE20CEE3};
    logic [3:0]  fl  [14] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, 4'b0000, 4'h0, 4'h0,
                              4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0010};
    int len;
    for (int i = 0; i < 14; i++) begin
      exp_q.delete();
      exp_q.push_back(idle_c(1'b0));
      push_seq(ins[i], fl[i], len);
      while (exp_q.size() < 4) exp_q.push_back(idle_c(1'b0));
      run(ins[i], 32'h0, 1'b0, fl[i], 4);
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (obs[k] !== exp_q[k]) begin
          fails++;
          $display("FAIL directed %08h cyc%0d: got %h expected %h", ins[i], k, obs[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [3:0]  fl;
    int len;
    for (int i = 0; i < 250; i++) begin
      ins = gen_instr();
      fl = 4'($urandom);
      exp_q.delete();
      exp_q.push_back(idle_c(1'b0));
      push_seq(ins, fl, len);
      while (exp_q.size() < 4) exp_q.push_back(idle_c(1'b0));
      run(ins, 32'h0, 1'b0, fl, 4);
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (obs[k] !== exp_q[k]) begin
          fails++;
          $display("FAIL random %08h fl=%h cyc%0d: got %h expected %h", ins, fl, k, obs[k], exp_q[k]);
        end
      end
    end
  endtask

  // Second instruction held valid while the first is busy: ignored until IDLE
  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [3:0]  fl;
    int la, lb, n;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: begin a = 32'h0040A103; b = 32'h00500093; end
        1: begin a = 32'h00500093; b = 32'h402081B3; end
        2: begin a = 32'h00208023; b = 32'h00208463; end
        default: begin
          a = gen_instr();
          for (int t = 0; t < 100 && decode(a) < 0; t++) a = gen_instr();
          b = gen_instr();
          for (int t = 0; t < 100 && decode(b) < 0; t++) b = gen_instr();
        end
      endcase
      fl = 4'($urandom);
      exp_q.delete();
      exp_q.push_back(idle_c(1'b0));
      push_seq(a, fl, la);
      exp_q.push_back(idle_c(1'b0));
      push_seq(b, fl, lb);
      n = 2 + la + lb;
      run(a, b, 1'b1, fl, n);
      for (int k = 0; k < n; k++) begin
        tests++;
        if (obs[k] !== exp_q[k]) begin
          fails++;
          $display("FAIL b2b %08h/%08h cyc%0d: got %h expected %h", a, b, k, obs[k], exp_q[k]);
        end
      end
    end
  endtask

  // Reset asserted during the LOAD cycle aborts the load without a done
  task automatic test_reset_mid();
    ctl_t e;
    int   len;
    exp_q.delete();
    push_seq(32'h0081A283, 4'h0, len);
    instr = 32'h0081A283;
    instr_valid = 1'b1;
    @(negedge clk);
    e = idle_c(1'b0);
    tests++;
    if (cap() !== e) begin
      fails++;
      $display("FAIL rstmid_accept: got %h expected %h", cap(), e);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (cap() !== exp_q[0]) begin
      fails++;
      $display("FAIL rstmid_addr: got %h expected %h", cap(), exp_q[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    e = '0;
    tests++;
    if (cap() !== e) begin
      fails++;
      $display("FAIL rstmid_load_masked: got %h expected %h", cap(), e);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = idle_c(1'b0);
      tests++;
      if (cap() !== e) begin
        fails++;
        $display("FAIL rstmid_after cyc%0d: got %h expected %h", k, cap(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    {V, C, N, Z} = 4'h0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
